bram_port_master: RTL
=====================

# bram_port_master

Request-side controller for the single-port, read-first block RAMs used in the core: the initiator that drives a RAM's `en`/`we`/`addr`/`di` pins and consumes its registered `dout`. It accepts load/store requests from a pipeline stage over a valid/ready handshake and returns load data over a second valid/ready channel with backpressure. Byte-masked stores are performed as read-modify-write, because the RAM has only a whole-word write enable.

## Interface
- `DATA_WIDTH`, 32: word width; must be a multiple of 8.
- `ADDR_WIDTH`, 10: word-address width; matches log2 of the RAM depth.
- `clk`  in  1  sole clock; RAM shares it.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready` at a rising edge.
- `req_we`  in  1  1 = store, 0 = load.
- `req_wstrb`  in  DATA_WIDTH/8  byte strobes; bit i covers bits [8i+7:8i]; ignored for loads.
- `req_addr`  in  ADDR_WIDTH  word address.
- `req_wdata`  in  DATA_WIDTH  store data.
- `rsp_valid`  out  1  load data available.
- `rsp_ready`  in  1  consumer takes the data.
- `rsp_rdata`  out  DATA_WIDTH  load data.
- `ram_en`  out  1  RAM enable.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  ADDR_WIDTH  RAM address.
- `ram_di`  out  DATA_WIDTH  RAM write data.
- `ram_dout`  in  DATA_WIDTH  RAM registered read data, valid the cycle after an enabled access.

## Operation
- FSM states: IDLE and RMW_WR. Reset state: IDLE.
- IDLE, `req_ready` rule: high when not in reset and either the request is a store, or the response credit allows it (below).
- IDLE, accepted load: drive `ram_en=1`, `ram_we=0`, `ram_addr=req_addr` combinationally in the same cycle. Set the in-flight flag for the next cycle.
- IDLE, accepted store with all strobes set: `ram_en=1`, `ram_we=1`, `ram_di=req_wdata`. Completes in one cycle. No response.
- IDLE, accepted store with strobes partially set:
  - Issue a RAM read of `req_addr`.
  - Latch addr, wdata and wstrb.
  - Go to RMW_WR. The in-flight flag is not set.
- IDLE, accepted store with all strobes clear: no RAM access, no response. Stay in IDLE.
- RMW_WR:
  - `req_ready=0`.
  - Drive `ram_en=1`, `ram_we=1`, latched addr.
  - `ram_di` = per byte, latched wdata where the strobe is set, else `ram_dout`.
  - Return to IDLE next cycle.
- Load capture: when the in-flight flag is set, `ram_dout` is pushed into the response FIFO at the end of that cycle.
- Response FIFO:
  - 2 entries, FIFO order.
  - `rsp_valid` = FIFO non-empty; `rsp_rdata` = head entry.
  - Pop on `rsp_valid && rsp_ready`.
- Response credit: a load is accepted only if (FIFO count + in-flight flag) < 2, or a pop occurs this cycle. `req_ready` therefore depends combinationally on `rsp_ready`; this is permitted.
- `ram_addr` and `ram_di` are don't-care when `ram_en=0`. They are driven to 0 in that case for determinism.
- Ordering: requests take effect in acceptance order. A load accepted the cycle after a store to the same address returns the stored data.

## Timing
- Load latency: accepted at cycle t → RAM read at t → captured at the t+1 edge → `rsp_valid` at t+2.
- Load throughput: 1 load/cycle sustained while `rsp_ready=1`.
- Full store: 1 cycle; the next request can be accepted at t+1.
- Partial store: 2 cycles (read at t, write at t+1). The next request can be accepted at t+2.
- Simultaneous push and pop on the FIFO: count unchanged, order preserved.
- FIFO full with `rsp_ready=0`: loads stall via `req_ready=0`; stores continue to be accepted.
- Reset:
  - While `rst=1`: `req_ready=0`, `rsp_valid=0`, `ram_en=0`, `ram_we=0`.
  - On reset, the FIFO and in-flight flag are cleared and the FSM goes to IDLE.
  - A pending RMW write is dropped; the RAM word keeps its old value.
  - Data from a load in flight is discarded.

## Test plan
- Back-to-back: store 0xDEADBEEF to addr 5 with wstrb=0xF, then load addr 5 the next cycle → `rsp_rdata=0xDEADBEEF` 2 cycles after the load is accepted.
- Partial store: word 0x11223344 at addr 7; store 0xAABBCCDD with wstrb=0b0101 → RMW takes 2 cycles with `req_ready=0` during RMW_WR; a subsequent load returns 0x11BB33DD.
- Backpressure:
  - With `rsp_ready=0`, issue 4 loads to addrs 0–3 → exactly 2 accepted, then `req_ready` stays 0 for loads.
  - Raise `rsp_ready` → data for addrs 0,1,2,3 returned in order with no loss or duplication.
- Streaming: 16 consecutive loads with `rsp_ready=1` → one accepted per cycle; responses are contiguous, starting 2 cycles after the first acceptance.
- Zero strobe: store 0xFFFFFFFF with wstrb=0 to addr 9 holding 0x0 → `ram_en` never asserted; a load of addr 9 returns 0x0.
- Reset mid-RMW: assert `rst` in the RMW_WR cycle of a partial store to addr 3 (old value 0x01020304) → `ram_we` low; after release, a load of addr 3 returns 0x01020304 and `rsp_valid` is 0 until then.

Source files
------------

// File: rtl/bram_port_master_if.sv
// Request/response/RAM-pin bundle for bram_port_master.
// The master modport is the controller; the slave modport is its environment (pipeline stage + RAM).
interface bram_port_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [DATA_WIDTH/8-1:0] req_wstrb;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    ram_en;
  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]   ram_di;
  logic [DATA_WIDTH-1:0]   ram_dout;

  modport master (
    input  req_valid, req_we, req_wstrb, req_addr, req_wdata, rsp_ready, ram_dout,
    output req_ready, rsp_valid, rsp_rdata, ram_en, ram_we, ram_addr, ram_di
  );

  modport slave (
    output req_valid, req_we, req_wstrb, req_addr, req_wdata, rsp_ready, ram_dout,
    input  req_ready, rsp_valid, rsp_rdata, ram_en, ram_we, ram_addr, ram_di
  );
endinterface

// File: rtl/bram_port_master.sv
// Load/store front end for a single-port read-first BRAM; partial stores become read-modify-write.
// state    | meaning
// S_IDLE   | accept requests; loads/full stores issue directly, partial stores issue their read
// S_RMW_WR | write back the merged word of a partial store; requests blocked
module bram_port_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                i_clk,
  input  logic                i_rst,
  bram_port_master_if.master  bus
);
  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic {S_IDLE, S_RMW_WR} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_inflight;
  logic                  w_inflight_nxt;
  logic [DATA_WIDTH-1:0] r_fifo [2];
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_count;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NB-1:0]         r_wstrb;

  logic                  w_rsp_valid;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_credit;
  logic                  w_req_ready;
  logic                  w_latch;
  logic [DATA_WIDTH-1:0] w_merge;

  assign w_rsp_valid = !i_rst && (r_count != 2'd0);
  assign w_pop       = w_rsp_valid && bus.rsp_ready;
  assign w_push      = r_inflight;
  // A load needs a guaranteed FIFO slot for when its data lands two cycles later.
  assign w_credit    = (({1'b0, r_count} + {2'b00, r_inflight}) < 3'd2) || w_pop;

  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = r_fifo[r_rd_ptr];
  assign bus.req_ready = w_req_ready;

  always_comb begin
    w_merge = '0;
    for (int i = 0; i < NB; i++) begin
      w_merge[8*i +: 8] = r_wstrb[i] ? r_wdata[8*i +: 8] : bus.ram_dout[8*i +: 8];
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_inflight_nxt = 1'b0;
    w_latch        = 1'b0;
    w_req_ready    = 1'b0;
    bus.ram_en     = 1'b0;
    bus.ram_we     = 1'b0;
    bus.ram_addr   = '0;
    bus.ram_di     = '0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = bus.req_we || w_credit;
        if (bus.req_valid && w_req_ready) begin
          if (!bus.req_we) begin
            bus.ram_en     = 1'b1;
            bus.ram_addr   = bus.req_addr;
            w_inflight_nxt = 1'b1;
          end else if (&bus.req_wstrb) begin
            bus.ram_en   = 1'b1;
            bus.ram_we   = 1'b1;
            bus.ram_addr = bus.req_addr;
            bus.ram_di   = bus.req_wdata;
          end else if (|bus.req_wstrb) begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = bus.req_addr;
            w_latch      = 1'b1;
            w_state_nxt  = S_RMW_WR;
          end
        end
      end
      S_RMW_WR: begin
        bus.ram_en   = 1'b1;
        bus.ram_we   = 1'b1;
        bus.ram_addr = r_addr;
        bus.ram_di   = w_merge;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Reset blocks RAM access immediately, which also drops a pending RMW write.
    if (i_rst) begin
      w_state_nxt    = S_IDLE;
      w_inflight_nxt = 1'b0;
      w_latch        = 1'b0;
      w_req_ready    = 1'b0;
      bus.ram_en     = 1'b0;
      bus.ram_we     = 1'b0;
      bus.ram_addr   = '0;
      bus.ram_di     = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_inflight <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_inflight_nxt;
      if (w_latch) begin
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_wstrb <= bus.req_wstrb;
      end
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      if (w_push && !w_pop)      r_count <= r_count + 2'd1;
      else if (w_pop && !w_push) r_count <= r_count - 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) r_fifo[r_wr_ptr] <= bus.ram_dout;
  end
endmodule
